stopwatch_ctrl: RTL

Sequencing controller for the watch's stopwatch counter chain. Conditions two raw push-buttons (start/stop and lap/reset), runs a four-state control FSM, and generates the enable tick, clear and display-snapshot strobes that drive the cascaded modulo counters and the display hold register. It sits between the board buttons and the counter chain and is the only block that decides when the chain counts, holds or clears.

---
 rtl/watch_pkg.sv | 17 +
 rtl/btn_conditioner.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// watch_pkg: state encoding shared by the stopwatch controller and the
// display/LED logic, plus a small helper for the "counting" states.
package watch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   // RUN and LAP both advance the counter chain; LAP only freezes the display.
   function automatic logic is_counting(input state_t s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions one raw asynchronous push-button.
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   btn    in  raw button level (asynchronous)
//   press  out one-cycle pulse on each debounced rising edge
// A 2-flop synchronizer feeds a debounce counter that runs while the
// synchronized sample disagrees with the accepted level. Once the count has
// reached DB_CYCLES and the sample still disagrees, the accepted level flips.
// Releases flip the level silently.
module btn_conditioner #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync1, sync2;
   logic          level;
   logic [CW-1:0] db_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         level  <= 1'b0;
         db_cnt <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            db_cnt <= '0;
         end else if (db_cnt == CW'(DB_CYCLES)) begin
            level  <= sync2;
            db_cnt <= '0;
            press  <= sync2;   // rising edges only
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequencing controller for the stopwatch counter chain.
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   btn_ss     in  raw start/stop button
//   btn_lr     in  raw lap/reset button
//   cnt_en     out one-cycle enable to the least-significant counter
//   cnt_clr    out one-cycle clear to the whole counter chain
//   snap_load  out one-cycle strobe, display register captures counts
//   disp_hold  out display shows the captured snapshot while high
//   state      out FSM state code (debug/LEDs)
// All outputs are registered. The prescaler only advances while counting, so
// a pause keeps the sub-tick phase and cnt_clr (issued from PAUSE) can never
// coincide with cnt_en.
module stopwatch_ctrl
   import watch_pkg::*;
#(
   parameter int TICK_DIV  = 100000,
   parameter int DB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_lr,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       snap_load,
   output logic       disp_hold,
   output logic [1:0] state
);

   localparam int PW = $clog2(TICK_DIV);

   state_t        st, st_nxt;
   logic          ss_p, lr_p;
   logic          clr_d, snap_d, hold_d;
   logic [PW-1:0] pre;

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_ss (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_ss),
      .press (ss_p)
   );

   btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_lr (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_lr),
      .press (lr_p)
   );

   // State register; strobes are registered alongside so they appear in the
   // same cycle as the new state.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= ST_IDLE;
         cnt_clr   <= 1'b0;
         snap_load <= 1'b0;
         disp_hold <= 1'b0;
      end else begin
         st        <= st_nxt;
         cnt_clr   <= clr_d;
         snap_load <= snap_d;
         disp_hold <= hold_d;
      end
   end

   // Next state: start/stop wins when both pulses land in the same cycle.
   always_comb begin
      st_nxt = st;
      if (ss_p) begin
         case (st)
            ST_IDLE:  st_nxt = ST_RUN;
            ST_RUN:   st_nxt = ST_PAUSE;
            ST_PAUSE: st_nxt = ST_RUN;
            ST_LAP:   st_nxt = ST_PAUSE;
            default:  st_nxt = ST_IDLE;
         endcase
      end else if (lr_p) begin
         case (st)
            ST_RUN:   st_nxt = ST_LAP;
            ST_LAP:   st_nxt = ST_RUN;
            ST_PAUSE: st_nxt = ST_IDLE;
            default:  st_nxt = st;
         endcase
      end
   end

   // Output decode (pre-register values).
   always_comb begin
      clr_d  = (st == ST_PAUSE) && lr_p && !ss_p;
      snap_d = (st == ST_RUN)   && lr_p && !ss_p;
      hold_d = (st_nxt == ST_LAP);
   end

   // Prescaler: terminal count while counting yields cnt_en next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre    <= '0;
         cnt_en <= 1'b0;
      end else begin
         cnt_en <= 1'b0;
         if (clr_d || st == ST_IDLE) begin
            pre <= '0;
         end else if (is_counting(st)) begin
            cnt_en <= (pre == PW'(TICK_DIV - 1));
            pre    <= (pre == PW'(TICK_DIV - 1)) ? '0 : pre + 1'b1;
         end
      end
   end

   assign state = st;

endmodule
